// File: rtl/gcd_arb_pkg.sv
// Shared definitions for the GCD arbiter: controller state encoding and default sizing.
package gcd_arb_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefNreq  = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/gcd.sv
// Subtractive GCD engine. Expects nonzero operands; pulses valid_o for one cycle when done.
module gcd
   import gcd_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] gcd_o
);

   localparam logic [1:0] EngIdle = 2'd0;
   localparam logic [1:0] EngBusy = 2'd1;
   localparam logic [1:0] EngDone = 2'd2;

   logic [1:0]       st_q, st_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q <= EngIdle;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         st_q <= st_d;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

   // One subtraction per cycle; the equality check costs a cycle of its own.
   always_comb begin
      st_d    = st_q;
      x_d     = x_q;
      y_d     = y_q;
      valid_o = 1'b0;
      case (st_q)
         EngIdle: begin
            if (valid_i) begin
               x_d  = a_i;
               y_d  = b_i;
               st_d = EngBusy;
            end
         end
         EngBusy: begin
            if (x_q == y_q) begin
               st_d = EngDone;
            end else if (x_q > y_q) begin
               x_d = x_q - y_q;
            end else begin
               y_d = y_q - x_q;
            end
         end
         EngDone: begin
            valid_o = 1'b1;
            st_d    = EngIdle;
         end
         default: st_d = EngIdle;
      endcase
   end

   assign gcd_o = x_q;

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing a single GCD engine among NREQ requesters, one job at a time.
module gcd_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned NREQ  = DefNreq,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [IDW-1:0]        resp_id_o,
   output logic [WIDTH-1:0]      resp_gcd_o,
   output logic                  busy_o
);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             found;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   winner;
   logic [WIDTH-1:0] win_a, win_b;

   logic             eng_rst;
   logic             eng_valid;
   logic             eng_done;
   logic [WIDTH-1:0] eng_gcd;

   assign eng_rst = ~reset_ni;

   gcd #(
      .WIDTH (WIDTH)
   ) u_gcd (
      .clk_i   (clk_i),
      .rst_i   (eng_rst),
      .valid_i (eng_valid),
      .a_i     (a_q),
      .b_i     (b_q),
      .valid_o (eng_done),
      .gcd_o   (eng_gcd)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q  <= StIdle;
         last_q   <= IDW'(NREQ - 1);
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      eng_valid   = 1'b0;
      req_ready_o = '0;
      found       = 1'b0;
      cand        = '0;
      winner      = '0;
      win_a       = '0;
      win_b       = '0;

      // Search starts just past the previous winner and wraps, so the previous winner is last.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDW'((32'(last_q) + k) % NREQ);
         if (!found && req_valid_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (winner == IDW'(i)) begin
            win_a = req_a_i[i*WIDTH +: WIDTH];
            win_b = req_b_i[i*WIDTH +: WIDTH];
         end
      end

      case (state_q)
         StIdle: begin
            if (found) begin
               req_ready_o = NREQ'(1) << winner;
               a_d         = win_a;
               b_d         = win_b;
               id_d        = winner;
               last_d      = winner;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            // A zero operand makes the answer the other operand (0 when both are zero).
            if (a_q == '0 || b_q == '0) begin
               result_d = a_q | b_q;
               state_d  = StResp;
            end else begin
               eng_valid = 1'b1;
               state_d   = StWait;
            end
         end
         StWait: begin
            if (eng_done) begin
               result_d = eng_gcd;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (resp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign resp_valid_o = (state_q == StResp);
   assign resp_id_o    = id_q;
   assign resp_gcd_o   = result_q;
   assign busy_o       = (state_q != StIdle);

endmodule
